alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer for the phase-1 ALU/Y/Z datapath. It accepts one ALU instruction at a time and steps the datapath through its cycles:
- operand A into Y;
- operand B on the bus with the opcode and Z latch;
- Z low (and, for mul/div, Z high) back to the register file or LO/HI.

It sits between the instruction decode/test bench and the bus-select, register-enable and ALU opcode inputs. It replaces hand-driven control signals.

## Interface
Parameters:
- MD_WAIT, 2: extra EXEC hold cycles for mul/div (0 = none).
- OPW, 5: opcode width.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op_in  in  OPW  opcode of request.
- flush  in  1  synchronous abort; return to IDLE.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in the final write-back cycle.
- err  out  1  one-cycle pulse when an illegal opcode is rejected.
- ra_out  out  1  drive source register A onto bus.
- rb_out  out  1  drive source register B onto bus.
- yin  out  1  load Y from bus.
- alu_op  out  OPW  opcode to ALU.
- zin  out  1  load 64-bit Z from ALU.
- zlo_out  out  1  drive Z[31:0] on bus.
- zhi_out  out  1  drive Z[63:32] on bus.
- rz_in  out  1  load destination register from bus.
- lo_in  out  1  load LO.
- hi_in  out  1  load HI.

## Operation
Opcode classes:
- Legal: add (00011) through not (10010).
- Illegal: ld/ldi/st (00000–00010) and anything ≥ 10011.
- Unary: neg, not.
- Mul/div: mul, div.

States are IDLE, LOAD_Y, EXEC, WAIT, WB_LO, WB_HI.

IDLE:
- On start with a legal op: latch op_r.
  - Unary → EXEC.
  - Otherwise → LOAD_Y.
- On start with an illegal op: err=1 for that cycle, stay in IDLE, op_r unchanged.

LOAD_Y:
- ra_out=1, yin=1.
- Next state EXEC.

EXEC:
- alu_op=op_r, zin=1.
- Bus driver: rb_out=1, except ra_out=1 for unary ops (the ALU takes the unary operand from the bus).
- Next state:
  - Mul/div with MD_WAIT>0 → WAIT, counter loaded with MD_WAIT-1.
  - Otherwise → WB_LO.

WAIT:
- EXEC outputs held identically.
- Counter decrements each cycle; at 0 → WB_LO.

WB_LO:
- zlo_out=1.
- Mul/div: lo_in=1 → WB_HI.
- Otherwise: rz_in=1, done=1 → IDLE.

WB_HI:
- zhi_out=1, hi_in=1, done=1.
- Next state IDLE.

Output rules:
- Outputs are a Moore decode of state and op_r only. No output depends combinationally on start or op_in, except err.
- alu_op = 00000 outside EXEC/WAIT.
- In any cycle at most one bus driver is asserted (ra_out, rb_out, zlo_out, zhi_out).

## Timing
Latency, with start sampled at edge 0 and done high during cycle N:
- Binary op: N=3.
- Unary op: N=2.
- Mul/div: N=4+MD_WAIT.

Back-to-back: start may be asserted in the cycle after done (IDLE). The next sequence begins with no gap cycle.

Boundary behaviour:
- start while busy: ignored and not queued.
- flush: wins over all transitions. Next state IDLE, no done, counter cleared. In the flush cycle the current-state outputs are still driven.
- flush together with start in IDLE: start is ignored.
- rst at any time (including mid-WAIT) forces the reset state immediately.
- Reset values: state=IDLE, op_r=00000, counter=0. All outputs 0: busy, done, err, ra_out, rb_out, yin, alu_op=00000, zin, zlo_out, zhi_out, rz_in, lo_in, hi_in.
- Counter width is $clog2(MD_WAIT+1), minimum 1. With MD_WAIT=0 the WAIT state is unreachable.

## Structure
- Shared package alu_pkg:
  - opcode localparams (ld … not, 00000–10010);
  - state enum;
  - OPW.
  The ALU and this controller both import it.
- One sub-module, alu_op_class: combinational, op → {legal, unary, muldiv}. It is reused by later decode.
- Everything else lives in one FSM module: state register, op_r, WAIT counter and output decode.

## Test plan
- add (00011), MD_WAIT=2:
  - cycle 1: ra_out, yin;
  - cycle 2: rb_out, zin, alu_op=00011;
  - cycle 3: zlo_out, rz_in, done;
  - busy high cycles 1–3.
- neg (10001):
  - no yin ever;
  - cycle 1: ra_out, zin, alu_op=10001;
  - cycle 2: zlo_out, rz_in, done.
- mul (01111), MD_WAIT=2:
  - EXEC/WAIT outputs held for cycles 2–4;
  - cycle 5: zlo_out, lo_in;
  - cycle 6: zhi_out, hi_in, done;
  - repeat with MD_WAIT=0: done at cycle 4.
- Illegal ops 10011 and 00001:
  - err pulses one cycle each, busy stays 0.
  - A following legal start is accepted normally.
- start with op=01010 asserted during the busy cycles of an add:
  - ignored; exactly one done; alu_op is 00011 throughout EXEC.
- Aborts mid-sequence:
  - flush in WAIT of div: IDLE next cycle, no done, no lo_in/hi_in.
  - rst asserted mid-EXEC without a clock edge: all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, controller state encoding and
// default opcode width. Imported by the ALU datapath and its sequencer.
package alu_pkg;

    localparam int ALU_OPW = 5;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ADDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Y,
        ST_EXEC,
        ST_WAIT,
        ST_WB_LO,
        ST_WB_HI
    } state_e;

    // WAIT counter width; never narrower than one bit so MD_WAIT=0 still builds.
    function automatic int cnt_width(input int md_wait);
        return (md_wait > 0) ? $clog2(md_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode classifier: legal ALU op, unary op, multi-cycle mul/div.
module alu_op_class
    import alu_pkg::*;
#(
    parameter int OPW = ALU_OPW
) (
    input  logic [OPW-1:0] op_i,
    output logic           legal_o,
    output logic           unary_o,
    output logic           muldiv_o
);

    logic [31:0] op_w;

    always_comb begin
        op_w     = 32'(op_i);
        legal_o  = (op_w >= 32'(OP_ADD)) && (op_w <= 32'(OP_NOT));
        unary_o  = (op_w == 32'(OP_NEG)) || (op_w == 32'(OP_NOT));
        muldiv_o = (op_w == 32'(OP_MUL)) || (op_w == 32'(OP_DIV));
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the ALU/Y/Z datapath: load Y, execute into Z,
// then write Z low (and Z high for mul/div) back. Outputs are a Moore decode.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int MD_WAIT = 2,
    parameter int OPW     = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] op_in,
    input  logic           flush,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           ra_out,
    output logic           rb_out,
    output logic           yin,
    output logic [OPW-1:0] alu_op,
    output logic           zin,
    output logic           zlo_out,
    output logic           zhi_out,
    output logic           rz_in,
    output logic           lo_in,
    output logic           hi_in
);

    localparam int                 CNT_W    = cnt_width(MD_WAIT);
    localparam logic [CNT_W-1:0]   CNT_LOAD = (MD_WAIT > 0) ? CNT_W'(MD_WAIT - 1) : '0;

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             unary_q, unary_d;
    logic             muldiv_q, muldiv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_legal, in_unary, in_muldiv;

    alu_op_class #(
        .OPW(OPW)
    ) u_class (
        .op_i    (op_in),
        .legal_o (in_legal),
        .unary_o (in_unary),
        .muldiv_o(in_muldiv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            unary_q  <= 1'b0;
            muldiv_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            unary_q  <= unary_d;
            muldiv_q <= muldiv_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        unary_d  = unary_q;
        muldiv_d = muldiv_q;
        cnt_d    = cnt_q;

        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        ra_out  = 1'b0;
        rb_out  = 1'b0;
        yin     = 1'b0;
        alu_op  = '0;
        zin     = 1'b0;
        zlo_out = 1'b0;
        zhi_out = 1'b0;
        rz_in   = 1'b0;
        lo_in   = 1'b0;
        hi_in   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (in_legal) begin
                        op_d     = op_in;
                        unary_d  = in_unary;
                        muldiv_d = in_muldiv;
                        state_d  = in_unary ? ST_EXEC : ST_LOAD_Y;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_LOAD_Y: begin
                busy    = 1'b1;
                ra_out  = 1'b1;
                yin     = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC, ST_WAIT: begin
                // Unary ops take their single operand straight from register A.
                busy   = 1'b1;
                alu_op = op_q;
                zin    = 1'b1;
                ra_out = unary_q;
                rb_out = !unary_q;
                if (state_q == ST_EXEC) begin
                    if (muldiv_q && (MD_WAIT > 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_WB_LO;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_WB_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB_LO: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
                if (muldiv_q) begin
                    lo_in   = 1'b1;
                    state_d = ST_WB_HI;
                end else begin
                    rz_in   = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB_HI: begin
                busy    = 1'b1;
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every transition but leaves this cycle's outputs intact.
        if (flush) begin
            state_d  = ST_IDLE;
            op_d     = op_q;
            unary_d  = unary_q;
            muldiv_d = muldiv_q;
            cnt_d    = '0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: cycle table plus reset/latency sequences.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       flush;
    logic [4:0] op_in;

    logic       busy, done, err, ra_out, rb_out, yin, zin, zlo_out, zhi_out, rz_in, lo_in, hi_in;
    logic [4:0] alu_op;
    logic       busy0, done0, err0, ra0, rb0, yin0, zin0, zlo0, zhi0, rz0, lo0, hi0;
    logic [4:0] alu_op0;

    alu_seq_ctrl #(.MD_WAIT(2), .OPW(5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_in(op_in), .flush(flush),
        .busy(busy), .done(done), .err(err), .ra_out(ra_out), .rb_out(rb_out),
        .yin(yin), .alu_op(alu_op), .zin(zin), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .rz_in(rz_in), .lo_in(lo_in), .hi_in(hi_in)
    );

    alu_seq_ctrl #(.MD_WAIT(0), .OPW(5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .op_in(op_in), .flush(flush),
        .busy(busy0), .done(done0), .err(err0), .ra_out(ra0), .rb_out(rb0),
        .yin(yin0), .alu_op(alu_op0), .zin(zin0), .zlo_out(zlo0), .zhi_out(zhi0),
        .rz_in(rz0), .lo_in(lo0), .hi_in(hi0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [4:0]  op;
        logic        fl;
        logic [17:0] exp;
    } vec_t;

    vec_t        tbl[$];
    int          checks   = 0;
    int          failures = 0;
    logic [17:0] obs;
    logic [17:0] obs0;

    assign obs  = {busy, done, err, ra_out, rb_out, yin, zin, zlo_out, zhi_out,
                   rz_in, lo_in, hi_in, alu_op, done0};
    assign obs0 = {busy0, done0, err0, ra0, rb0, yin0, zin0, zlo0, zhi0,
                   rz0, lo0, hi0, alu_op0, 1'b0};

    function automatic logic [17:0] E(
        input logic b, d, e, ra, rb, y, z, zl, zh, rz, lo, hi,
        input logic [4:0] alu, input logic d0);
        return {b, d, e, ra, rb, y, z, zl, zh, rz, lo, hi, alu, d0};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%b want=%b (busy,done,err,ra,rb,yin,zin,zlo,zhi,rz,lo,hi,alu[5],done0)",
                     name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, expv);
        end
    endtask

    function automatic void row(input logic st, input logic [4:0] op, input logic fl,
                                input logic [17:0] e);
        vec_t v;
        v.st = st; v.op = op; v.fl = fl; v.exp = e;
        tbl.push_back(v);
    endfunction

    localparam logic [17:0] Z = '0;

    initial begin
        int lat2, lat0, n2, n0;

        //     b d e ra rb y z zl zh rz lo hi alu      d0
        row(1, OP_ADD, 0, Z);
        row(0, OP_ADD, 0, E(1,0,0,1,0,1,0,0,0,0,0,0,5'b00000,0));
        row(0, OP_ADD, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_ADD,  0));
        row(0, OP_ADD, 0, E(1,1,0,0,0,0,0,1,0,1,0,0,5'b00000,1));
        row(1, OP_NEG, 0, Z);
        row(0, OP_NEG, 0, E(1,0,0,1,0,0,1,0,0,0,0,0,OP_NEG,  0));
        row(0, OP_NEG, 0, E(1,1,0,0,0,0,0,1,0,1,0,0,5'b00000,1));
        row(1, OP_MUL, 0, Z);
        row(0, OP_MUL, 0, E(1,0,0,1,0,1,0,0,0,0,0,0,5'b00000,0));
        row(0, OP_MUL, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_MUL,  0));
        row(0, OP_MUL, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_MUL,  0));
        row(0, OP_MUL, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_MUL,  1));
        row(0, OP_MUL, 0, E(1,0,0,0,0,0,0,1,0,0,1,0,5'b00000,0));
        row(0, OP_MUL, 0, E(1,1,0,0,0,0,0,0,1,0,0,1,5'b00000,0));
        row(1, 5'b10011, 0, E(0,0,1,0,0,0,0,0,0,0,0,0,5'b00000,0));
        row(1, 5'b00001, 0, E(0,0,1,0,0,0,0,0,0,0,0,0,5'b00000,0));
        row(1, OP_ADD, 0, Z);
        row(1, 5'b01010, 0, E(1,0,0,1,0,1,0,0,0,0,0,0,5'b00000,0));
        row(1, 5'b01010, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_ADD,  0));
        row(1, 5'b01010, 0, E(1,1,0,0,0,0,0,1,0,1,0,0,5'b00000,1));
        row(0, 5'b01010, 0, Z);
        row(1, OP_DIV, 0, Z);
        row(0, OP_DIV, 0, E(1,0,0,1,0,1,0,0,0,0,0,0,5'b00000,0));
        row(0, OP_DIV, 0, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_DIV,  0));
        row(0, OP_DIV, 1, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_DIV,  0));
        row(0, OP_DIV, 0, Z);
        row(1, OP_ADD, 1, Z);
        row(0, OP_ADD, 0, Z);

        rst = 1'b1; start = 1'b0; flush = 1'b0; op_in = '0;
        #2;
        check("reset_outputs", obs, Z);
        check("reset_outputs_md0", obs0, Z);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st;
            op_in = tbl[i].op;
            flush = tbl[i].fl;
            #1;
            check($sformatf("row%0d", i), obs, tbl[i].exp);
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;

        // Asynchronous reset while in EXEC of an add.
        start = 1'b1; op_in = OP_ADD;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_exec", obs, E(1,0,0,0,1,0,1,0,0,0,0,0,OP_ADD,0));
        #2 rst = 1'b1;
        #1;
        check("async_rst_exec", obs, Z);
        check("async_rst_exec_md0", obs0, Z);
        @(negedge clk);
        rst = 1'b0;

        // Mul latency on both MD_WAIT settings, with a cycle budget.
        start = 1'b1; op_in = OP_MUL;
        @(negedge clk);
        start = 1'b0;
        lat2 = -1; lat0 = -1; n2 = 0; n0 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done === 1'b1) begin n2++; if (lat2 < 0) lat2 = c; end
            if (done0 === 1'b1) begin n0++; if (lat0 < 0) lat0 = c; end
            @(negedge clk);
        end
        check_int("mul_latency_md2", lat2, 6);
        check_int("mul_latency_md0", lat0, 4);
        check_int("mul_done_count_md2", n2, 1);
        check_int("mul_done_count_md0", n0, 1);

        // Unary op after reset recovery: two-cycle latency.
        start = 1'b1; op_in = OP_NOT;
        @(negedge clk);
        start = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1 && lat2 < 0) lat2 = c;
            @(negedge clk);
        end
        check_int("not_latency", lat2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
